// File: rtl/udp_pkg.sv
// Shared definitions for the UDP receive path: header layout, port width,
// one-hot state encoding and the network-to-host byte swap.
package udp_pkg;

    localparam int PORT_W = 16;

    // UDP header is always eight bytes long
    localparam logic [15:0] HDR_LEN = 16'd8;

    // Byte offsets of the header fields, counted from the first UDP byte
    localparam logic [15:0] SRC_OFF  = 16'd0;
    localparam logic [15:0] DST_OFF  = 16'd2;
    localparam logic [15:0] LEN_OFF  = 16'd4;
    localparam logic [15:0] CSUM_OFF = 16'd6;

    // One-hot state encoding
    localparam logic [3:0] ST_IDLE_ENC = 4'b0001;
    localparam logic [3:0] ST_HEAD_ENC = 4'b0010;
    localparam logic [3:0] ST_DATA_ENC = 4'b0100;
    localparam logic [3:0] ST_DROP_ENC = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_HEAD = ST_HEAD_ENC,
        ST_DATA = ST_DATA_ENC,
        ST_DROP = ST_DROP_ENC
    } udp_state_t;

    // The lower byte of a bus word is first on the wire, so a big-endian
    // header field arrives with its bytes swapped relative to host order.
    function automatic logic [15:0] to_host(input logic [15:0] word);
        return {word[7:0], word[15:8]};
    endfunction

endpackage

// File: rtl/udp_port_match.sv
// Compares a header port field against a fixed value when the word at the
// configured byte index goes by, and flags a mismatch for that cycle.
module udp_port_match
    import udp_pkg::*;
#(
    parameter logic [15:0]       BYTE_IDX = 16'd0,
    parameter logic [PORT_W-1:0] PORT     = '0,
    parameter bit                ENABLE   = 1'b1
) (
    input  logic              hdr_valid,
    input  logic [15:0]       byte_idx,
    input  logic [PORT_W-1:0] field,
    output logic              mismatch
);

    // A disabled matcher never objects; otherwise only the indexed word counts
    always_comb begin
        mismatch = ENABLE && hdr_valid && (byte_idx == BYTE_IDX) && (field != PORT);
    end

endmodule

// File: rtl/udp_rx.sv
// UDP receive stage: strips the 8-byte UDP header from the IPv4 payload,
// filters on ports, length and IPv4 checksum status, and forwards exactly
// (length - 8) payload bytes to the application, hiding Ethernet padding.
module udp_rx
    import udp_pkg::*;
#(
    parameter int          DATA_W         = 16,
    parameter int          MATCH_DST_PORT = 1,
    parameter logic [15:0] DST_PORT       = 16'd18000,
    parameter int          MATCH_SRC_PORT = 0,
    parameter logic [15:0] SRC_PORT       = 16'd18001,
    localparam int         LEN_W          = $clog2(DATA_W/8+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic              cancel_i,
    input  logic              cs_err_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              valid_o,
    output logic              start_o,
    output logic              end_o,
    output logic              cancel_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              len_err_o
);

    udp_state_t  state;
    udp_state_t  state_next;
    logic [15:0] byte_cnt;
    logic [15:0] remaining;
    logic        first_pend;

    logic [15:0] len_in16;
    logic [15:0] field;
    logic [15:0] cur_idx;
    logic        hdr_word;
    logic        src_mis;
    logic        dst_mis;
    logic        len_short;
    logic        len_empty;
    logic        discard;
    logic        data_fire;
    logic        end_word;

    assign len_in16 = 16'(len_i);
    assign field    = to_host(data_i[15:0]);

    // A start word is always header word 0, whatever state we are in
    assign cur_idx  = start_i ? 16'd0 : byte_cnt;
    assign hdr_word = valid_i & ~cancel_i & (start_i | (state == ST_HEAD));

    assign len_short = hdr_word & (cur_idx == LEN_OFF) & (field <  HDR_LEN);
    assign len_empty = hdr_word & (cur_idx == LEN_OFF) & (field == HDR_LEN);
    assign discard   = (hdr_word & start_i & cs_err_i) | src_mis | dst_mis | len_short;

    assign data_fire = (state == ST_DATA) & valid_i & ~start_i;
    assign end_word  = data_fire & (remaining <= len_in16);

    udp_port_match #(
        .BYTE_IDX (SRC_OFF),
        .PORT     (SRC_PORT),
        .ENABLE   (MATCH_SRC_PORT != 0)
    ) u_src_match (
        .hdr_valid (hdr_word),
        .byte_idx  (cur_idx),
        .field     (field),
        .mismatch  (src_mis)
    );

    udp_port_match #(
        .BYTE_IDX (DST_OFF),
        .PORT     (DST_PORT),
        .ENABLE   (MATCH_DST_PORT != 0)
    ) u_dst_match (
        .hdr_valid (hdr_word),
        .byte_idx  (cur_idx),
        .field     (field),
        .mismatch  (dst_mis)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: cancel wins, then only valid words move the machine
    always_comb begin
        state_next = state;
        if (cancel_i) begin
            state_next = ST_IDLE;
        end else if (valid_i) begin
            if (start_i) begin
                state_next = discard ? ST_DROP : ST_HEAD;
            end else begin
                unique case (state)
                    ST_HEAD: begin
                        if (discard) begin
                            state_next = ST_DROP;
                        end else if (len_empty) begin
                            state_next = ST_IDLE;
                        end else if (cur_idx == CSUM_OFF) begin
                            state_next = ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (end_word) begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: state_next = state;
                endcase
            end
        end
    end

    // Outputs: payload passes straight through, clipped to the UDP length
    always_comb begin
        valid_o   = data_fire;
        start_o   = data_fire & first_pend;
        end_o     = end_word;
        cancel_o  = cancel_i & ((state == ST_HEAD) | (state == ST_DATA));
        len_err_o = len_short;
        data_o    = '0;
        len_o     = '0;
        if (data_fire) begin
            data_o = data_i;
            len_o  = (remaining < len_in16) ? remaining[LEN_W-1:0] : len_i;
        end
    end

    // Header byte position, payload bytes still owed and first-word marker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt   <= '0;
            remaining  <= '0;
            first_pend <= 1'b0;
        end else if (cancel_i) begin
            byte_cnt   <= '0;
            remaining  <= '0;
            first_pend <= 1'b0;
        end else begin
            if (valid_i && start_i) begin
                byte_cnt <= len_in16;
            end else if (state == ST_IDLE) begin
                byte_cnt <= '0;
            end else if (valid_i) begin
                byte_cnt <= byte_cnt + len_in16;
            end

            if (hdr_word && (cur_idx == LEN_OFF)) begin
                remaining <= field - HDR_LEN;
            end else if (data_fire) begin
                remaining <= remaining - 16'(len_o);
            end

            if ((state_next == ST_DATA) && (state != ST_DATA)) begin
                first_pend <= 1'b1;
            end else if (data_fire) begin
                first_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// Directed bench for udp_rx: header filtering, length clipping, drop,
// cancel, reset and restart behaviour, with hand-computed expectations.
module tb_udp_rx;

    localparam int LEN_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_i;
    logic             start_i;
    logic             cancel_i;
    logic             cs_err_i;
    logic [15:0]      data_i;
    logic [LEN_W-1:0] len_i;
    logic             valid_o;
    logic             start_o;
    logic             end_o;
    logic             cancel_o;
    logic [15:0]      data_o;
    logic [LEN_W-1:0] len_o;
    logic             len_err_o;

    int checks = 0;
    int errors = 0;

    udp_rx dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .start_i   (start_i),
        .cancel_i  (cancel_i),
        .cs_err_i  (cs_err_i),
        .data_i    (data_i),
        .len_i     (len_i),
        .valid_o   (valid_o),
        .start_o   (start_o),
        .end_o     (end_o),
        .cancel_o  (cancel_o),
        .data_o    (data_o),
        .len_o     (len_o),
        .len_err_o (len_err_o)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // One comparison: count it, and on mismatch count and report it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of input on the falling edge, settle before checking
    task automatic applyStimulus(input logic v, input logic s, input logic c,
                                 input logic cs, input logic [15:0] d,
                                 input logic [LEN_W-1:0] l);
        @(negedge clk);
        valid_i  = v;
        start_i  = s;
        cancel_i = c;
        cs_err_i = cs;
        data_i   = d;
        len_i    = l;
        #1;
    endtask

    // Host-order field to bus word (low byte first on the wire)
    function automatic logic [15:0] wire16(input logic [15:0] host);
        return {host[7:0], host[15:8]};
    endfunction

    // Idle cycles with valid_i low; nothing may come out
    task automatic idleGap(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 2'd2);
            checkOutput({tag, " gap"}, {29'd0, valid_o, start_o, end_o}, 32'd0);
        end
    endtask

    // Four header words; gap_step idle cycles times the word number before each
    task automatic sendHeader(input string tag, input logic [15:0] src,
                              input logic [15:0] dst, input logic [15:0] len,
                              input logic cs, input int gap_step,
                              input logic exp_len_err);
        logic [15:0] w [4];
        w[0] = wire16(src);
        w[1] = wire16(dst);
        w[2] = wire16(len);
        w[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idleGap(tag, gap_step * i);
            applyStimulus(1'b1, (i == 0), 1'b0, (i == 0) ? cs : 1'b0, w[i], 2'd2);
            checkOutput($sformatf("%s hdr%0d", tag, i),
                        {27'd0, valid_o, start_o, end_o, cancel_o, len_err_o},
                        {27'd0, 4'b0000, (i == 2) ? exp_len_err : 1'b0});
        end
    endtask

    // One full payload word on the input and its expected output
    task automatic payloadWord(input string tag, input logic [15:0] d,
                               input logic exp_v, input logic exp_s,
                               input logic exp_e, input logic [LEN_W-1:0] exp_len);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, d, 2'd2);
        checkOutput({tag, " ctl"}, {29'd0, valid_o, start_o, end_o},
                    {29'd0, exp_v, exp_s, exp_e});
        if (exp_v) begin
            checkOutput({tag, " len"}, {30'd0, len_o}, {30'd0, exp_len});
            checkOutput({tag, " data"}, {16'd0, data_o}, {16'd0, d});
        end
    endtask

    initial begin
        reset    = 1'b1;
        valid_i  = 1'b0;
        start_i  = 1'b0;
        cancel_i = 1'b0;
        cs_err_i = 1'b0;
        data_i   = '0;
        len_i    = '0;

        // Reset holds everything quiet even with a start word present
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h5146, 2'd2);
        checkOutput("reset outs",
                    {9'd0, valid_o, start_o, end_o, cancel_o, len_err_o, len_o, data_o},
                    32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0);
        reset = 1'b0;

        // Basic packet: length 12, four payload bytes in two words
        sendHeader("A", 16'd18001, 16'd18000, 16'd12, 1'b0, 0, 1'b0);
        payloadWord("A w1", 16'hAABB, 1'b1, 1'b1, 1'b0, 2'd2);
        payloadWord("A w2", 16'hCCDD, 1'b1, 1'b0, 1'b1, 2'd2);
        payloadWord("A post", 16'h1234, 1'b0, 1'b0, 1'b0, 2'd0);

        // Length 11: three payload bytes, padding words suppressed
        sendHeader("B", 16'd18001, 16'd18000, 16'd11, 1'b0, 0, 1'b0);
        payloadWord("B w1", 16'h1111, 1'b1, 1'b1, 1'b0, 2'd2);
        payloadWord("B w2", 16'h2222, 1'b1, 1'b0, 1'b1, 2'd1);
        payloadWord("B pad1", 16'h3333, 1'b0, 1'b0, 1'b0, 2'd0);
        payloadWord("B pad2", 16'h4444, 1'b0, 1'b0, 1'b0, 2'd0);

        // Wrong destination port dropped, back-to-back good packet delivered
        sendHeader("C", 16'd18001, 16'd18001, 16'd12, 1'b0, 0, 1'b0);
        payloadWord("C w1", 16'h5555, 1'b0, 1'b0, 1'b0, 2'd0);
        payloadWord("C w2", 16'h6666, 1'b0, 1'b0, 1'b0, 2'd0);
        sendHeader("C2", 16'd18001, 16'd18000, 16'd12, 1'b0, 0, 1'b0);
        payloadWord("C2 w1", 16'h7777, 1'b1, 1'b1, 1'b0, 2'd2);
        payloadWord("C2 w2", 16'h8888, 1'b1, 1'b0, 1'b1, 2'd2);

        // IPv4 checksum error on the start word drops the packet
        sendHeader("D", 16'd18001, 16'd18000, 16'd12, 1'b1, 0, 1'b0);
        payloadWord("D w1", 16'h9999, 1'b0, 1'b0, 1'b0, 2'd0);
        payloadWord("D w2", 16'hAAAA, 1'b0, 1'b0, 1'b0, 2'd0);

        // Length 6 is short: length-error pulse on the length word, then drop
        sendHeader("E", 16'd18001, 16'd18000, 16'd6, 1'b0, 0, 1'b1);
        payloadWord("E w1", 16'hBBBB, 1'b0, 1'b0, 1'b0, 2'd0);

        // Length exactly 8: empty payload, nothing delivered
        sendHeader("F", 16'd18001, 16'd18000, 16'd8, 1'b0, 0, 1'b0);
        payloadWord("F w1", 16'hCCCC, 1'b0, 1'b0, 1'b0, 2'd0);

        // Cancel on the second payload word, then back in IDLE
        sendHeader("G", 16'd18001, 16'd18000, 16'd16, 1'b0, 0, 1'b0);
        payloadWord("G w1", 16'h0102, 1'b1, 1'b1, 1'b0, 2'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0304, 2'd2);
        checkOutput("G cancel_o", {31'd0, cancel_o}, 32'd1);
        checkOutput("G cancel end_o", {31'd0, end_o}, 32'd0);
        payloadWord("G after", 16'h0506, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0);
        checkOutput("G idle cancel_o", {31'd0, cancel_o}, 32'd0);

        // Reset mid-DATA silences outputs at once; no output until a new start
        sendHeader("H", 16'd18001, 16'd18000, 16'd16, 1'b0, 0, 1'b0);
        payloadWord("H w1", 16'h1357, 1'b1, 1'b1, 1'b0, 2'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h2468, 2'd2);
        checkOutput("H pre-reset valid", {31'd0, valid_o}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("H reset outs",
                    {9'd0, valid_o, start_o, end_o, cancel_o, len_err_o, len_o, data_o},
                    32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0);
        reset = 1'b0;
        payloadWord("H post", 16'h3579, 1'b0, 1'b0, 1'b0, 2'd0);

        // Start in DATA abandons the old packet and parses the new one
        sendHeader("I", 16'd18001, 16'd18000, 16'd16, 1'b0, 0, 1'b0);
        payloadWord("I w1", 16'hDEAD, 1'b1, 1'b1, 1'b0, 2'd2);
        sendHeader("I2", 16'd18001, 16'd18000, 16'd12, 1'b0, 0, 1'b0);
        payloadWord("I2 w1", 16'hBEEF, 1'b1, 1'b1, 1'b0, 2'd2);
        payloadWord("I2 w2", 16'hCAFE, 1'b1, 1'b0, 1'b1, 2'd2);

        // Same as packet A but with 1-3 cycle valid gaps everywhere
        sendHeader("J", 16'd18001, 16'd18000, 16'd12, 1'b0, 1, 1'b0);
        idleGap("J", 2);
        payloadWord("J w1", 16'hAABB, 1'b1, 1'b1, 1'b0, 2'd2);
        idleGap("J", 3);
        payloadWord("J w2", 16'hCCDD, 1'b1, 1'b0, 1'b1, 2'd2);
        idleGap("J", 1);
        payloadWord("J post", 16'h1234, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
